// File: rtl/mema_sched_pkg.sv
// rtl/mema_sched_pkg.sv - shared types, defaults and lane-mask helper for the memA chunk scheduler
//
// Purpose: FSM state encoding, default parameter values and the pure lane-mask
// function used by every per-module chunk counter.
// Ports: none (package).

package mema_sched_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RUN      = 3'd2,
        ROW_DONE = 3'd3,
        DONE     = 3'd4
    } sched_state_t;

    localparam int DEF_N_ELEM  = 20;
    localparam int DEF_MODULES = 4;
    localparam int DEF_UNITS   = 8;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_CNT_W   = 32;

    // Widest chunk the helper can describe; callers take the low `units` bits.
    localparam int MASK_MAX = 64;

    // Lanes of chunk `index` (1-based) that still hold real elements.
    // Bit units-1 is lane 0, so a partial chunk sets its top bits (data packed
    // high, zero padding low). The remainder is kept signed and wide so chunks
    // past the end of the row produce an empty mask instead of wrapping.
    function automatic logic [MASK_MAX-1:0] lane_mask_f(
        input logic [MASK_MAX-1:0] index,
        input int                  n_elem,
        input int                  units
    );
        logic [MASK_MAX-1:0] m;
        longint              rem;
        m   = '0;
        rem = longint'(n_elem) - longint'(index - 64'd1) * longint'(units);
        for (int i = 0; i < MASK_MAX; i++) begin
            if (i < units && longint'(units - 1 - i) < rem) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/mema_chunk_counter.sv
// rtl/mema_chunk_counter.sv - per-module chunk index, valid, last and lane mask with ready edge detect
//
// Purpose: tracks one consumer module's progress through the chunks of the
// current row. A rising edge on `ready` consumes the outstanding chunk.
// Ports:
//   clk, rst      clock, async active-high reset
//   load          reload counters from `multiples` (index 1)
//   multiples     chunk count for this module, sampled on load
//   ready         consumer ready level
//   run_en        handshakes are accepted only while high
//   chunk_index   1-based current chunk
//   chunk_valid   a chunk is outstanding
//   last_chunk    current chunk is the final one
//   lane_mask     valid lanes of the current chunk, MSB = lane 0

module mema_chunk_counter
    import mema_sched_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int UNITS  = DEF_UNITS,
    parameter int N_ELEM = DEF_N_ELEM
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] multiples,
    input  logic             ready,
    input  logic             run_en,
    output logic [CNT_W-1:0] chunk_index,
    output logic             chunk_valid,
    output logic             last_chunk,
    output logic [UNITS-1:0] lane_mask
);

    logic [CNT_W-1:0]    mult_r;
    logic                ready_prev;
    logic                accept;
    logic [CNT_W-1:0]    n_idx;
    logic [CNT_W-1:0]    n_mult;
    logic                n_valid;
    logic                n_last;
    logic [UNITS-1:0]    n_mask;
    logic [MASK_MAX-1:0] mask_wide;
    logic                unused_mask_hi;

    // Only a fresh rising edge counts; a held-high ready consumes one chunk.
    assign accept = run_en & chunk_valid & ready & ~ready_prev;

    always_comb begin
        n_idx   = chunk_index;
        n_mult  = mult_r;
        n_valid = chunk_valid;
        n_last  = last_chunk;
        if (load) begin
            n_mult  = multiples;
            n_idx   = {{(CNT_W-1){1'b0}}, 1'b1};
            n_valid = (multiples != '0);
            n_last  = (multiples == {{(CNT_W-1){1'b0}}, 1'b1});
        end else if (accept) begin
            if (chunk_index < mult_r) begin
                n_idx  = chunk_index + 1'b1;
                n_last = ((chunk_index + 1'b1) == mult_r);
            end else begin
                n_valid = 1'b0;
                n_last  = 1'b0;
            end
        end
    end

    // Mask follows the index it will be registered with.
    assign mask_wide      = lane_mask_f(MASK_MAX'(n_idx), N_ELEM, UNITS);
    assign n_mask         = n_valid ? mask_wide[UNITS-1:0] : '0;
    assign unused_mask_hi = ^(mask_wide >> UNITS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mult_r      <= '0;
            ready_prev  <= 1'b0;
            chunk_index <= {{(CNT_W-1){1'b0}}, 1'b1};
            chunk_valid <= 1'b0;
            last_chunk  <= 1'b0;
            lane_mask   <= '0;
        end else begin
            ready_prev  <= ready;
            mult_r      <= n_mult;
            chunk_index <= n_idx;
            chunk_valid <= n_valid;
            last_chunk  <= n_last;
            lane_mask   <= n_mask;
        end
    end

endmodule

// File: rtl/mema_chunk_scheduler.sv
// rtl/mema_chunk_scheduler.sv - row/chunk sequencer for matrix-A reads feeding the row-by-vector modules
//
// Purpose: walks no_of_rows memA rows from base_address; within a row each
// consumer module steps through its own chunks on its ready edges, and the row
// advances once every module has consumed all of its chunks.
// Ports:
//   clk, rst            clock, async active-high reset
//   start               begins a pass (IDLE only)
//   base_address        first row address
//   no_of_rows          number of rows in the pass
//   no_of_multiples     per-module chunk counts, cnt_width each
//   i_am_ready          per-module ready levels
//   memA_read_address   current row address
//   chunk_index         per-module 1-based chunk index
//   chunk_valid         per-module chunk outstanding
//   last_chunk          per-module final-chunk flag
//   lane_mask           per-module valid lanes, MSB = lane 0
//   busy                pass in progress
//   done                one-cycle completion pulse

module mema_chunk_scheduler
    import mema_sched_pkg::*;
#(
    parameter int no_of_elements_on_col_nos   = DEF_N_ELEM,
    parameter int no_of_row_by_vector_modules = DEF_MODULES,
    parameter int no_of_units                 = DEF_UNITS,
    parameter int addr_width                  = DEF_ADDR_W,
    parameter int cnt_width                   = DEF_CNT_W
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic [addr_width-1:0]                             base_address,
    input  logic [cnt_width-1:0]                              no_of_rows,
    input  logic [cnt_width*no_of_row_by_vector_modules-1:0]  no_of_multiples,
    input  logic [no_of_row_by_vector_modules-1:0]            i_am_ready,
    output logic [addr_width-1:0]                             memA_read_address,
    output logic [cnt_width*no_of_row_by_vector_modules-1:0]  chunk_index,
    output logic [no_of_row_by_vector_modules-1:0]            chunk_valid,
    output logic [no_of_row_by_vector_modules-1:0]            last_chunk,
    output logic [no_of_units*no_of_row_by_vector_modules-1:0] lane_mask,
    output logic                                              busy,
    output logic                                              done
);

    localparam int M  = no_of_row_by_vector_modules;
    localparam int U  = no_of_units;
    localparam int CW = cnt_width;

    sched_state_t       state;
    sched_state_t       state_nxt;
    logic [addr_width-1:0] base_q;
    logic [CW-1:0]      rows_q;
    logic [CW-1:0]      rows_left;
    logic [CW*M-1:0]    mult_q;
    logic [CW*M-1:0]    load_mult;
    logic               load_cnt;
    logic               run_en;
    logic               all_idle;

    assign all_idle = ~|chunk_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start) state_nxt = LOAD;
            LOAD:     state_nxt = (rows_q == '0) ? DONE : RUN;
            RUN:      if (all_idle) state_nxt = ROW_DONE;
            ROW_DONE: state_nxt = (rows_left == {{(CW-1){1'b0}}, 1'b1}) ? DONE : RUN;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        run_en   = (state == RUN);
        load_cnt = 1'b0;
        if (state == LOAD && rows_q != '0) begin
            load_cnt = 1'b1;
        end
        if (state == ROW_DONE && rows_left != {{(CW-1){1'b0}}, 1'b1}) begin
            load_cnt = 1'b1;
        end
    end

    // First row uses the counts captured with start; later rows pick up the
    // live input so software may retune counts between rows.
    assign load_mult = (state == LOAD) ? mult_q : no_of_multiples;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q            <= '0;
            rows_q            <= '0;
            mult_q            <= '0;
            rows_left         <= '0;
            memA_read_address <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base_address;
                        rows_q <= no_of_rows;
                        mult_q <= no_of_multiples;
                    end
                end
                LOAD: begin
                    memA_read_address <= base_q;
                    rows_left         <= rows_q;
                end
                ROW_DONE: begin
                    rows_left <= rows_left - 1'b1;
                    if (rows_left != {{(CW-1){1'b0}}, 1'b1}) begin
                        memA_read_address <= memA_read_address + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar m = 0; m < M; m++) begin : g_cnt
        mema_chunk_counter #(
            .CNT_W  (CW),
            .UNITS  (U),
            .N_ELEM (no_of_elements_on_col_nos)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .load        (load_cnt),
            .multiples   (load_mult[(m+1)*CW-1 -: CW]),
            .ready       (i_am_ready[m]),
            .run_en      (run_en),
            .chunk_index (chunk_index[(m+1)*CW-1 -: CW]),
            .chunk_valid (chunk_valid[m]),
            .last_chunk  (last_chunk[m]),
            .lane_mask   (lane_mask[(m+1)*U-1 -: U])
        );
    end

endmodule

// File: tb/tb_mema_chunk_scheduler.sv
// tb/tb_mema_chunk_scheduler.sv - self-checking bench for mema_chunk_scheduler

module tb_mema_chunk_scheduler;

    localparam int M  = 4;
    localparam int U  = 8;
    localparam int CW = 32;
    localparam int AW = 32;
    localparam int NE = 20;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   base_address = '0;
    logic [CW-1:0]   no_of_rows = '0;
    logic [CW*M-1:0] no_of_multiples = '0;
    logic [M-1:0]    i_am_ready = '0;
    logic [AW-1:0]   memA_read_address;
    logic [CW*M-1:0] chunk_index;
    logic [M-1:0]    chunk_valid;
    logic [M-1:0]    last_chunk;
    logic [U*M-1:0]  lane_mask;
    logic            busy;
    logic            done;

    mema_chunk_scheduler dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .base_address      (base_address),
        .no_of_rows        (no_of_rows),
        .no_of_multiples   (no_of_multiples),
        .i_am_ready        (i_am_ready),
        .memA_read_address (memA_read_address),
        .chunk_index       (chunk_index),
        .chunk_valid       (chunk_valid),
        .last_chunk        (last_chunk),
        .lane_mask         (lane_mask),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 load, 2 run, 3 row done, 4 done
    int            m_phase;
    logic [AW-1:0] m_addr;
    logic [CW-1:0] m_rows;
    logic [AW-1:0] cap_base;
    logic [CW-1:0] cap_rows;
    logic [CW*M-1:0] cap_mult;
    logic [CW-1:0] m_idx  [M];
    logic [CW-1:0] m_mult [M];
    logic [M-1:0]  m_valid;
    logic [M-1:0]  m_prev;

    function automatic logic [7:0] ref_mask(input logic [CW-1:0] idx);
        int rem;
        rem = NE - (int'(idx) - 1) * U;
        if (rem >= U) return 8'hFF;
        if (rem <= 0) return 8'h00;
        return 8'(8'hFF << (U - rem));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase  <= 0;
            m_addr   <= '0;
            m_rows   <= '0;
            m_prev   <= '0;
            m_valid  <= '0;
            cap_base <= '0;
            cap_rows <= '0;
            cap_mult <= '0;
            for (int m = 0; m < M; m++) begin
                m_idx[m]  <= 1;
                m_mult[m] <= '0;
            end
        end else begin
            m_prev <= i_am_ready;
            case (m_phase)
                0: if (start) begin
                    cap_base <= base_address;
                    cap_rows <= no_of_rows;
                    cap_mult <= no_of_multiples;
                    m_phase  <= 1;
                end
                1: begin
                    m_addr <= cap_base;
                    m_rows <= cap_rows;
                    if (cap_rows == 0) begin
                        m_phase <= 4;
                    end else begin
                        for (int m = 0; m < M; m++) begin
                            m_idx[m]   <= 1;
                            m_mult[m]  <= cap_mult[m*CW +: CW];
                            m_valid[m] <= (cap_mult[m*CW +: CW] != 0);
                        end
                        m_phase <= 2;
                    end
                end
                2: begin
                    if (m_valid == '0) m_phase <= 3;
                    for (int m = 0; m < M; m++) begin
                        if (m_valid[m] && i_am_ready[m] && !m_prev[m]) begin
                            if (m_idx[m] < m_mult[m]) m_idx[m] <= m_idx[m] + 1;
                            else m_valid[m] <= 1'b0;
                        end
                    end
                end
                3: begin
                    m_rows <= m_rows - 1;
                    if (m_rows == 1) begin
                        m_phase <= 4;
                    end else begin
                        m_addr <= m_addr + 1;
                        for (int m = 0; m < M; m++) begin
                            m_idx[m]   <= 1;
                            m_mult[m]  <= no_of_multiples[m*CW +: CW];
                            m_valid[m] <= (no_of_multiples[m*CW +: CW] != 0);
                        end
                        m_phase <= 2;
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    logic [CW*M-1:0] e_idx;
    logic [M-1:0]    e_last;
    logic [U*M-1:0]  e_mask;

    always_comb begin
        e_idx  = '0;
        e_last = '0;
        e_mask = '0;
        for (int m = 0; m < M; m++) begin
            e_idx[m*CW +: CW] = m_idx[m];
            e_last[m]         = m_valid[m] && (m_idx[m] == m_mult[m]);
            e_mask[m*U +: U]  = m_valid[m] ? ref_mask(m_idx[m]) : 8'h00;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_addr",  256'(memA_read_address), 256'(m_addr));
            chk("cyc_index", 256'(chunk_index),       256'(e_idx));
            chk("cyc_valid", 256'(chunk_valid),       256'(m_valid));
            chk("cyc_last",  256'(last_chunk),        256'(e_last));
            chk("cyc_mask",  256'(lane_mask),         256'(e_mask));
            chk("cyc_busy",  256'(busy),              256'(m_phase != 0));
            chk("cyc_done",  256'(done),              256'(m_phase == 4));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input logic [AW-1:0] b, input logic [CW-1:0] r, input logic [CW*M-1:0] mu);
        base_address    = b;
        no_of_rows      = r;
        no_of_multiples = mu;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
    endtask

    task automatic pulse(input logic [M-1:0] msk, input int gap);
        i_am_ready = msk;
        tick(1);
        i_am_ready = '0;
        tick(gap);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (done) seen = 1'b1;
            else tick(1);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wait_done actual=timeout required=done_pulse");
        end
    endtask

    localparam logic [CW*M-1:0] IDX1 = {4{32'd1}};
    localparam logic [CW*M-1:0] IDX2 = {4{32'd2}};
    localparam logic [CW*M-1:0] IDX3 = {4{32'd3}};

    initial begin
        #1 rst = 1'b1;
        tick(1);
        chk_on = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_index", 256'(chunk_index), 256'(IDX1));
        chk("rst_busy",  256'(busy), 256'(0));
        tick(1);

        // single row, equal multiples
        start_pass(32'h10, 1, IDX3);
        chk("t1_idx1",  256'(chunk_index), 256'(IDX1));
        chk("t1_mask1", 256'(lane_mask),   256'(32'hFFFF_FFFF));
        pulse(4'hF, 0);
        chk("t1_idx2",  256'(chunk_index), 256'(IDX2));
        chk("t1_mask2", 256'(lane_mask),   256'(32'hFFFF_FFFF));
        tick(3);
        pulse(4'hF, 0);
        chk("t1_idx3",  256'(chunk_index), 256'(IDX3));
        chk("t1_mask3", 256'(lane_mask),   256'(32'hF0F0_F0F0));
        chk("t1_last3", 256'(last_chunk),  256'(4'hF));
        tick(3);
        pulse(4'hF, 0);
        chk("t1_valid0", 256'(chunk_valid), 256'(4'h0));
        chk("t1_hold3",  256'(chunk_index), 256'(IDX3));
        tick(2);
        chk("t1_done",  256'(done), 256'(1));
        chk("t1_addr",  256'(memA_read_address), 256'(32'h10));
        tick(2);

        // unequal multiples, two rows
        start_pass(32'h20, 2, {32'd1, 32'd2, 32'd3, 32'd0});
        chk("t2_valid", 256'(chunk_valid), 256'(4'b1110));
        chk("t2_last",  256'(last_chunk),  256'(4'b1000));
        pulse(4'hF, 2);
        pulse(4'hF, 2);
        chk("t2_valid_mid", 256'(chunk_valid), 256'(4'b0010));
        pulse(4'hF, 2);
        chk("t2_addr_row2", 256'(memA_read_address), 256'(32'h21));
        chk("t2_idx_row2",  256'(chunk_index), 256'(IDX1));
        chk("t2_valid_row2", 256'(chunk_valid), 256'(4'b1110));
        pulse(4'hF, 2);
        pulse(4'hF, 2);
        pulse(4'hF, 0);
        wait_done(10);
        chk("t2_addr_end", 256'(memA_read_address), 256'(32'h21));
        tick(2);

        // zero rows
        no_of_rows = 0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t3_busy_load", 256'(busy), 256'(1));
        chk("t3_valid",     256'(chunk_valid), 256'(4'h0));
        tick(1);
        chk("t3_done",      256'(done), 256'(1));
        tick(1);
        chk("t3_idle",      256'(busy), 256'(0));
        tick(1);

        // held ready, then an edge during ROW_DONE
        start_pass(32'h30, 2, IDX2);
        i_am_ready = 4'hF;
        tick(10);
        i_am_ready = '0;
        chk("t4_one_adv", 256'(chunk_index), 256'(IDX2));
        chk("t4_last",    256'(last_chunk),  256'(4'hF));
        tick(1);
        pulse(4'hF, 1);
        i_am_ready = 4'hF;
        tick(1);
        i_am_ready = '0;
        chk("t4_reload_idx", 256'(chunk_index), 256'(IDX1));
        chk("t4_addr",       256'(memA_read_address), 256'(32'h31));
        tick(1);
        chk("t4_not_queued", 256'(chunk_index), 256'(IDX1));
        pulse(4'hF, 3);
        pulse(4'hF, 0);
        wait_done(10);
        tick(2);

        // asynchronous reset mid-run
        start_pass(32'h40, 1, IDX3);
        pulse(4'hF, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_idx",   256'(chunk_index), 256'(IDX1));
        chk("t5_async_valid", 256'(chunk_valid), 256'(4'h0));
        chk("t5_async_addr",  256'(memA_read_address), 256'(0));
        chk("t5_async_busy",  256'(busy), 256'(0));
        tick(1);
        rst = 1'b0;
        tick(1);
        start_pass(32'h40, 1, IDX3);
        chk("t5_rerun_addr",  256'(memA_read_address), 256'(32'h40));
        pulse(4'hF, 3);
        pulse(4'hF, 3);
        pulse(4'hF, 0);
        wait_done(10);
        tick(2);

        // start while busy is ignored
        start_pass(32'h50, 1, IDX1);
        base_address = 32'h99;
        no_of_rows   = 5;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t6_addr_run", 256'(memA_read_address), 256'(32'h50));
        pulse(4'hF, 0);
        wait_done(10);
        chk("t6_addr_end", 256'(memA_read_address), 256'(32'h50));
        tick(4);
        chk("t6_no_rerun", 256'(busy), 256'(0));

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
